iq_wakeup_select: RTL and testbench

- Age-ordered issue-queue scheduler between the dispatch stage and one functional unit (ALU0, ALU1, MDU or LSU).
- Accepts up to 2 dispatched instructions per cycle and holds them in a compacting queue.
- Wakes up source operands from the 2 CDB broadcast ports.
- Each cycle it selects the oldest entry whose two sources are ready and offers it to the unit over a valid/ready handshake.

---
 rtl/iq_wakeup_select_if.sv | 33 +++
 rtl/iq_wakeup_select.sv | 101 ++++++++++
 tb/tb_iq_wakeup_select.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_wakeup_select_if.sv
// Dispatch, CDB wakeup and issue signals of one issue-queue scheduler.
// Handshake: lane l is enqueued at the edge when enq_valid_i[l] & enq_ready_o; the
// selected entry issues at the edge when iss_valid_o & iss_ready_i, and the unit
// samples iss_payload_o only in that cycle. Offers may change while ready is low.
interface iq_wakeup_select_if #(
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 128,
   parameter int CNT_W     = 4
) ();
   logic [1:0]                        enq_valid_i;
   logic                              enq_ready_o;
   logic [1:0][1:0][PREG_W-1:0]       enq_src_preg_i;
   logic [1:0][1:0]                   enq_src_rdy_i;
   logic [1:0][PAYLOAD_W-1:0]         enq_payload_i;
   logic [1:0]                        wk_valid_i;
   logic [1:0][PREG_W-1:0]            wk_preg_i;
   logic                              iss_valid_o;
   logic                              iss_ready_i;
   logic [PAYLOAD_W-1:0]              iss_payload_o;
   logic [CNT_W-1:0]                  count_o;

   modport slave (
      input  enq_valid_i, enq_src_preg_i, enq_src_rdy_i, enq_payload_i,
      input  wk_valid_i, wk_preg_i, iss_ready_i,
      output enq_ready_o, iss_valid_o, iss_payload_o, count_o
   );

   modport master (
      output enq_valid_i, enq_src_preg_i, enq_src_rdy_i, enq_payload_i,
      output wk_valid_i, wk_preg_i, iss_ready_i,
      input  enq_ready_o, iss_valid_o, iss_payload_o, count_o
   );
endinterface

// File: rtl/iq_wakeup_select.sv
// Age-ordered compacting issue queue: 2-wide dispatch, 2-port CDB wakeup and
// oldest-ready select toward a single functional unit.
module iq_wakeup_select #(
   parameter int DEPTH     = 8,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   iq_wakeup_select_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic                   valid;
      logic [1:0][PREG_W-1:0] preg;
      logic [1:0]             rdy;
      logic [PAYLOAD_W-1:0]   payload;
   } entry_t;

   entry_t               ent_q [DEPTH];
   entry_t               ent_d [DEPTH];
   entry_t               ext   [DEPTH+1];
   entry_t               lane_ent [2];
   logic [CNT_W-1:0]     count_q, count_d, survivors, slot1;
   logic [DEPTH-1:0]     cand, take;
   logic                 found, above, enq_ready, iss_valid, issue_fire, acc0, acc1;
   logic [PAYLOAD_W-1:0] sel_payload;

   function automatic logic wk_hit(input logic [PREG_W-1:0]      tag,
                                   input logic [1:0]             wv,
                                   input logic [1:0][PREG_W-1:0] wp);
      return (wv[0] && (wp[0] == tag)) || (wv[1] && (wp[1] == tag));
   endfunction

   // Oldest-ready select as a one-hot priority pick over the age-ordered slots.
   always_comb begin
      cand        = '0;
      take        = '0;
      found       = 1'b0;
      sel_payload = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cand[i] = ent_q[i].valid & (&ent_q[i].rdy);
         take[i] = cand[i] & ~found;
         found   = found | cand[i];
         if (take[i]) sel_payload = sel_payload | ent_q[i].payload;
      end
   end

   assign enq_ready  = (count_q <= CNT_W'(DEPTH - 2));
   assign iss_valid  = found & ~flush_i;
   assign issue_fire = iss_valid & bus.iss_ready_i;
   assign acc0       = bus.enq_valid_i[0] & enq_ready;
   assign acc1       = bus.enq_valid_i[1] & enq_ready;

   assign bus.enq_ready_o   = enq_ready;
   assign bus.iss_valid_o   = iss_valid;
   assign bus.iss_payload_o = sel_payload;
   assign bus.count_o       = count_q;

   // Shift out the issued slot, wake the shifted image, then append the lanes.
   always_comb begin
      above       = 1'b0;
      ext[DEPTH]  = '0;
      for (int i = 0; i < DEPTH; i++) ext[i] = ent_q[i];
      for (int l = 0; l < 2; l++) begin
         lane_ent[l].valid   = 1'b1;
         lane_ent[l].preg    = bus.enq_src_preg_i[l];
         lane_ent[l].payload = bus.enq_payload_i[l];
         for (int s = 0; s < 2; s++)
            lane_ent[l].rdy[s] = bus.enq_src_rdy_i[l][s] |
                                 wk_hit(bus.enq_src_preg_i[l][s], bus.wk_valid_i, bus.wk_preg_i);
      end
      survivors = count_q - CNT_W'(issue_fire);
      slot1     = survivors + CNT_W'(acc0);
      for (int i = 0; i < DEPTH; i++) begin
         above    = above | take[i];
         ent_d[i] = (issue_fire && above) ? ext[i+1] : ext[i];
         for (int s = 0; s < 2; s++)
            if (wk_hit(ent_d[i].preg[s], bus.wk_valid_i, bus.wk_preg_i)) ent_d[i].rdy[s] = 1'b1;
         if (acc0 && (survivors == CNT_W'(i))) ent_d[i] = lane_ent[0];
         if (acc1 && (slot1 == CNT_W'(i)))     ent_d[i] = lane_ent[1];
         if (flush_i) ent_d[i].valid = 1'b0;
      end
      count_d = flush_i ? '0 : (survivors + CNT_W'(acc0) + CNT_W'(acc1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_iq_wakeup_select.sv
// Bench for iq_wakeup_select: directed vector table, corner-case sequences and
// random traffic checked against a queue-based scheduler model.
module tb_iq_wakeup_select;
   localparam int DEPTH = 8, PREG_W = 6, PAYLOAD_W = 128, CNT_W = 4;

   logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
   always #5 clk = ~clk;

   iq_wakeup_select_if #(.PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) bus ();

   iq_wakeup_select #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .bus(bus.slave)
   );

   int n_checks = 0, n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [1:0][PREG_W-1:0] preg;
      logic [1:0]             rdy;
      logic [PAYLOAD_W-1:0]   pl;
   } m_ent_t;

   m_ent_t               mq[$];
   int                   m_sel;
   logic                 m_iv, m_er;
   logic [PAYLOAD_W-1:0] m_pl;
   int                   m_cnt;

   function automatic logic hit(input logic [PREG_W-1:0] t);
      return (bus.wk_valid_i[0] && bus.wk_preg_i[0] == t) || (bus.wk_valid_i[1] && bus.wk_preg_i[1] == t);
   endfunction

   function automatic void predict();
      m_sel = -1;
      for (int i = 0; i < mq.size(); i++)
         if (m_sel < 0 && mq[i].rdy == 2'b11) m_sel = i;
      m_iv  = (m_sel >= 0) && !flush_i;
      m_pl  = (m_sel >= 0) ? mq[m_sel].pl : '0;
      m_cnt = mq.size();
      m_er  = (DEPTH - mq.size()) >= 2;
   endfunction

   function automatic void model_update();
      m_ent_t e;
      if (flush_i) begin
         mq.delete();
         return;
      end
      if (m_iv && bus.iss_ready_i) mq.delete(m_sel);
      for (int i = 0; i < mq.size(); i++) begin
         e = mq[i];
         for (int s = 0; s < 2; s++) if (hit(e.preg[s])) e.rdy[s] = 1'b1;
         mq[i] = e;
      end
      if (m_er)
         for (int l = 0; l < 2; l++)
            if (bus.enq_valid_i[l]) begin
               e.preg = bus.enq_src_preg_i[l];
               e.pl   = bus.enq_payload_i[l];
               for (int s = 0; s < 2; s++) e.rdy[s] = bus.enq_src_rdy_i[l][s] | hit(e.preg[s]);
               mq.push_back(e);
            end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle();
      bus.enq_valid_i    = '0;
      bus.enq_src_preg_i = '0;
      bus.enq_src_rdy_i  = '0;
      bus.enq_payload_i  = '0;
      bus.wk_valid_i     = '0;
      bus.wk_preg_i      = '0;
      bus.iss_ready_i    = 1'b0;
      flush_i            = 1'b0;
   endtask

   task automatic set_lane(input int l, input logic [PREG_W-1:0] t0, input logic r0,
                           input logic [PREG_W-1:0] t1, input logic r1, input logic [31:0] pl);
      bus.enq_valid_i[l]       = 1'b1;
      bus.enq_src_preg_i[l][0] = t0;
      bus.enq_src_preg_i[l][1] = t1;
      bus.enq_src_rdy_i[l]     = {r1, r0};
      bus.enq_payload_i[l]     = {96'h0, pl};
   endtask

   task automatic sample(input string tag);
      @(negedge clk);
      predict();
      check({tag, ":iss_valid"},   bus.iss_valid_o,   m_iv);
      check({tag, ":iss_payload"}, bus.iss_payload_o, m_pl);
      check({tag, ":count"},       bus.count_o,       m_cnt);
      check({tag, ":enq_ready"},   bus.enq_ready_o,   m_er);
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]        enq_v;
      logic [PREG_W-1:0] t0;
      logic              r0;
      logic [31:0]       pl0, pl1;
      logic [1:0]        wk_v;
      logic [PREG_W-1:0] wk_p0, wk_p1;
      logic              iss_rdy;
      logic              exp_iv;
      logic [31:0]       exp_pl;
      logic [CNT_W-1:0]  exp_cnt;
      logic              exp_er;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [1:0] ev, input logic [PREG_W-1:0] t0, input logic r0,
                               input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] wv,
                               input logic [PREG_W-1:0] w0, input logic [PREG_W-1:0] w1, input logic ir,
                               input logic xiv, input logic [31:0] xpl, input logic [CNT_W-1:0] xc,
                               input logic xer);
      vec_t v;
      v.enq_v = ev; v.t0 = t0; v.r0 = r0; v.pl0 = p0; v.pl1 = p1;
      v.wk_v = wv; v.wk_p0 = w0; v.wk_p1 = w1; v.iss_rdy = ir;
      v.exp_iv = xiv; v.exp_pl = xpl; v.exp_cnt = xc; v.exp_er = xer;
      return v;
   endfunction

   initial begin
      //           enq_v  t0 r0 pl0    pl1    wk_v  w0 w1 ir  iv pl     cnt er
      vecs[0]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 0, 'h0,  0, 1);
      vecs[1]  = mk(2'b11, 0, 1, 'h11, 'h22, 2'b00, 0, 0, 1, 0, 'h0,  0, 1);
      vecs[2]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 1, 'h11, 2, 1);
      vecs[3]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 1, 'h22, 1, 1);
      vecs[4]  = mk(2'b01, 5, 0, 'h33, 'h0,  2'b00, 0, 0, 1, 0, 'h0,  0, 1);
      vecs[5]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 0, 'h0,  1, 1);
      vecs[6]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b10, 0, 5, 1, 0, 'h0,  1, 1);
      vecs[7]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 1, 'h33, 1, 1);
      vecs[8]  = mk(2'b01, 9, 0, 'h44, 'h0,  2'b01, 9, 0, 1, 0, 'h0,  0, 1);
      vecs[9]  = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 1, 'h44, 1, 1);
      vecs[10] = mk(2'b10, 0, 1, 'h0,  'h55, 2'b00, 0, 0, 0, 0, 'h0,  0, 1);
      vecs[11] = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 0, 1, 'h55, 1, 1);
      vecs[12] = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 1, 'h55, 1, 1);
      vecs[13] = mk(2'b00, 0, 1, 'h0,  'h0,  2'b00, 0, 0, 1, 0, 'h0,  0, 1);
   end

   // ---------------- test sequence ----------------
   initial begin
      idle();
      #12;
      check("reset:count",       bus.count_o,       0);
      check("reset:iss_valid",   bus.iss_valid_o,   0);
      check("reset:iss_payload", bus.iss_payload_o, 0);
      check("reset:enq_ready",   bus.enq_ready_o,   1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int r = 0; r < NV; r++) begin
         idle();
         if (vecs[r].enq_v[0]) set_lane(0, vecs[r].t0, vecs[r].r0, 0, 1, vecs[r].pl0);
         if (vecs[r].enq_v[1]) set_lane(1, 0, 1, 0, 1, vecs[r].pl1);
         bus.wk_valid_i   = vecs[r].wk_v;
         bus.wk_preg_i[0] = vecs[r].wk_p0;
         bus.wk_preg_i[1] = vecs[r].wk_p1;
         bus.iss_ready_i  = vecs[r].iss_rdy;
         sample("tbl");
         check($sformatf("tbl%0d:iss_valid", r),   bus.iss_valid_o,   vecs[r].exp_iv);
         check($sformatf("tbl%0d:iss_payload", r), bus.iss_payload_o, {96'h0, vecs[r].exp_pl});
         check($sformatf("tbl%0d:count", r),       bus.count_o,       vecs[r].exp_cnt);
         check($sformatf("tbl%0d:enq_ready", r),   bus.enq_ready_o,   vecs[r].exp_er);
         advance();
      end

      // Age order: older A waits, younger ready B issues; woken A beats newer C.
      idle(); set_lane(0, 20, 0, 0, 1, 'hA1); sample("age1"); advance();
      idle(); set_lane(0, 0, 1, 0, 1, 'hB2); sample("age2"); check("age:a_blocked", bus.iss_valid_o, 0); advance();
      idle(); bus.iss_ready_i = 1'b1; sample("age3"); check("age:b_first", bus.iss_payload_o, 'hB2); advance();
      idle(); bus.wk_valid_i = 2'b01; bus.wk_preg_i[0] = 20; sample("age4"); check("age:wake_lat", bus.iss_valid_o, 0); advance();
      idle(); set_lane(0, 0, 1, 0, 1, 'hC3); bus.iss_ready_i = 1'b1; sample("age5");
      check("age:a_before_c", bus.iss_payload_o, 'hA1); advance();
      idle(); bus.iss_ready_i = 1'b1; sample("age6"); check("age:c_last", bus.iss_payload_o, 'hC3); advance();

      // Fill with never-ready entries; index 0 waits on tag 41, the rest on 40.
      for (int k = 0; k < 4; k++) begin
         idle();
         set_lane(0, (k == 0) ? 6'd41 : 6'd40, 0, (k == 0) ? 6'd0 : 6'd40, (k == 0), 'h70 + k);
         set_lane(1, 40, 0, 40, 0, 'h80 + k);
         sample("fill");
         if (k == 3) begin
            check("fill:count6", bus.count_o, 6);
            check("fill:ready6", bus.enq_ready_o, 1);
         end
         advance();
      end
      idle(); bus.wk_valid_i = 2'b10; bus.wk_preg_i[1] = 41; sample("full");
      check("full:count8", bus.count_o, 8); check("full:ready8", bus.enq_ready_o, 0); advance();
      idle(); bus.iss_ready_i = 1'b1; set_lane(0, 0, 1, 0, 1, 'hEE); set_lane(1, 0, 1, 0, 1, 'hEF);
      sample("full_iss"); check("full:issue_idx0", bus.iss_payload_o, 'h70); advance();
      idle(); sample("full7"); check("full:count7", bus.count_o, 7); check("full:ready7", bus.enq_ready_o, 0); advance();
      idle(); flush_i = 1'b1; sample("clr"); advance();

      // Flush at count 5 with an issue pending and a full dispatch group.
      for (int k = 0; k < 3; k++) begin
         idle(); set_lane(0, 0, 1, 0, 1, 'h60 + 2 * k);
         if (k < 2) set_lane(1, 0, 1, 0, 1, 'h61 + 2 * k);
         sample("pre_flush"); advance();
      end
      idle(); set_lane(0, 0, 1, 0, 1, 'hF0); set_lane(1, 0, 1, 0, 1, 'hF1);
      bus.iss_ready_i = 1'b1; flush_i = 1'b1; sample("flush");
      check("flush:count5", bus.count_o, 5); check("flush:iss_gated", bus.iss_valid_o, 0); advance();
      idle(); sample("post_flush");
      check("post_flush:count", bus.count_o, 0); check("post_flush:iss_valid", bus.iss_valid_o, 0);
      check("post_flush:enq_ready", bus.enq_ready_o, 1); advance();

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         idle();
         bus.enq_valid_i = 2'($urandom_range(0, 3));
         for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < 2; s++) begin
               bus.enq_src_preg_i[l][s] = PREG_W'($urandom_range(0, 7));
               bus.enq_src_rdy_i[l][s]  = ($urandom_range(0, 2) == 0);
            end
            bus.enq_payload_i[l] = {$urandom, $urandom, $urandom, $urandom};
         end
         bus.wk_valid_i   = 2'($urandom_range(0, 3));
         bus.wk_preg_i[0] = PREG_W'($urandom_range(0, 7));
         bus.wk_preg_i[1] = PREG_W'($urandom_range(0, 7));
         bus.iss_ready_i  = ((c % 300) < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         flush_i          = ($urandom_range(0, 49) == 0);
         sample("rnd");
         advance();
      end

      // Asynchronous reset in the middle of traffic.
      idle(); set_lane(0, 0, 1, 0, 1, 'hD0); set_lane(1, 3, 0, 0, 1, 'hD1); sample("pre_rst"); advance();
      rst_n = 1'b0;
      #2;
      mq.delete();
      check("mid_rst:count",     bus.count_o,     0);
      check("mid_rst:iss_valid", bus.iss_valid_o, 0);
      check("mid_rst:enq_ready", bus.enq_ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(); sample("after_rst"); advance();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
